// File: rtl/rs_enc_255_239.sv
// rs_enc_255_239: systematic RS(255,239) encoder over GF(2^8) (poly 0x11D, alpha 0x02)
// with a valid/ready stream in, a registered valid/ready stream out, and sop/eop/parity flags.
module rs_enc_255_239 #(
  parameter int N = 255,
  parameter int K = 239
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic       in_valid,
  input  logic [7:0] in_data,
  output logic       in_ready,
  output logic       out_valid,
  output logic [7:0] out_data,
  input  logic       out_ready,
  output logic       out_sop,
  output logic       out_eop,
  output logic       out_par
);
  localparam logic [7:0] LAST_D = 8'(K - 1);
  localparam logic [7:0] LAST_P = 8'(N - K - 1);
  typedef enum logic {DATA, PARITY} state_t;
  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] r, x;
    r = '0;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) r ^= x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1d : 8'h00);
    end
    return r;
  endfunction
  // g(x) = prod (x + alpha^i), built at elaboration so each g_i multiply folds to constant XORs
  function automatic logic [15:0][7:0] gen_poly();
    logic [16:0][7:0] g;
    logic [7:0] r;
    g = '0;
    g[0] = 8'h01;
    r = 8'h01;
    for (int i = 0; i < 16; i++) begin
      for (int j = 16; j > 0; j--) g[j] = g[j-1] ^ gf_mul(r, g[j]);
      g[0] = gf_mul(r, g[0]);
      r = gf_mul(r, 8'h02);
    end
    return g[15:0];
  endfunction
  localparam logic [15:0][7:0] G = gen_poly();
  state_t state, state_n;
  logic [7:0] cnt, cnt_n, fb, od_n;
  logic [15:0][7:0] p, p_n;
  logic slot_free, accept, par_load, ov_n, sop_n, eop_n, par_n;
  assign slot_free = out_ready | ~out_valid;
  assign in_ready = (state == DATA) & slot_free;
  assign accept = in_valid & in_ready;
  assign par_load = (state == PARITY) & slot_free;
  assign fb = in_data ^ p[15];
  always_comb begin
    state_n = state;
    cnt_n = cnt;
    p_n = p;
    ov_n = accept | par_load | (out_valid & ~out_ready);
    od_n = out_data;
    sop_n = out_sop;
    eop_n = out_eop;
    par_n = out_par;
    if (accept) begin
      p_n = {p[14:0], 8'h00};
      for (int i = 0; i < 16; i++) p_n[i] ^= gf_mul(G[i], fb);
      od_n = in_data;
      sop_n = cnt == 8'd0;
      eop_n = 1'b0;
      par_n = 1'b0;
      cnt_n = cnt == LAST_D ? 8'd0 : cnt + 8'd1;
      state_n = cnt == LAST_D ? PARITY : DATA;
    end else if (par_load) begin
      p_n = {p[14:0], 8'h00};
      od_n = p[15];
      sop_n = 1'b0;
      eop_n = cnt == LAST_P;
      par_n = 1'b1;
      cnt_n = cnt == LAST_P ? 8'd0 : cnt + 8'd1;
      state_n = cnt == LAST_P ? DATA : PARITY;
    end
  end
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state <= DATA;
      cnt <= '0;
      p <= '0;
      out_valid <= 1'b0;
      out_data <= '0;
      out_sop <= 1'b0;
      out_eop <= 1'b0;
      out_par <= 1'b0;
    end else begin
      state <= state_n;
      cnt <= cnt_n;
      p <= p_n;
      out_valid <= ov_n;
      out_data <= od_n;
      out_sop <= sop_n;
      out_eop <= eop_n;
      out_par <= par_n;
    end
  end
endmodule
